// File: rtl/icetap_capture_ctrl.sv
// Capture sequencer for the icetap logic analyzer: walks IDLE/PRE/ARMED/POST/DONE, drives the
// capture RAM write port and the readout pointer, all in the sampled-signal clock domain.
module icetap_capture_ctrl #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              src_clk,
  input  logic              reset_,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_code,
  input  logic [ADDR_W-1:0] cmd_pre_trig,
  input  logic              store_match,
  input  logic              trigger_match,
  output logic              ram_wr_ena,
  output logic [ADDR_W-1:0] ram_wr_addr,
  input  logic              rd_start,
  input  logic              rd_next,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [2:0]        status_state,
  output logic [ADDR_W-1:0] status_trig_addr
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPre   = 3'd1,
    StArmed = 3'd2,
    StPost  = 3'd3,
    StDone  = 3'd4
  } state_e;

  localparam logic [1:0] CmdArm   = 2'd1;
  localparam logic [1:0] CmdAbort = 2'd2;
  localparam logic [1:0] CmdForce = 2'd3;

  localparam logic [ADDR_W-1:0] One    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] MaxCnt = '1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0]   pre_q, pre_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;

  logic                cmd_arm, cmd_abort, cmd_force;
  logic                wr_en;
  logic [ADDR_W-1:0]   cnt_inc;
  logic [ADDR_W-1:0]   post_cnt;

  assign cmd_arm   = cmd_valid && (cmd_code == CmdArm);
  assign cmd_abort = cmd_valid && (cmd_code == CmdAbort);
  assign cmd_force = cmd_valid && (cmd_code == CmdForce);
  assign cnt_inc   = cnt_q + One;
  // Post-trigger samples still to take so the buffer ends up exactly DEPTH deep.
  assign post_cnt  = MaxCnt - pre_q;

  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    trig_addr_d = trig_addr_q;
    pre_d       = pre_q;
    cnt_d       = cnt_q;
    wr_en       = 1'b0;

    // ARM and ABORT take priority over any match on the same cycle.
    if (cmd_arm) begin
      wr_addr_d = '0;
      cnt_d     = '0;
      pre_d     = cmd_pre_trig;
      state_d   = (cmd_pre_trig == '0) ? StArmed : StPre;
    end else if (cmd_abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StPre: begin
          if (store_match) begin
            wr_en = 1'b1;
            cnt_d = cnt_inc;
            if (cnt_inc == pre_q) state_d = StArmed;
          end
        end
        StArmed: begin
          if (trigger_match || cmd_force) begin
            wr_en       = 1'b1;
            trig_addr_d = wr_addr_q;
            cnt_d       = post_cnt;
            state_d     = (post_cnt == '0) ? StDone : StPost;
          end else if (store_match) begin
            wr_en = 1'b1;
          end
        end
        StPost: begin
          if (store_match) begin
            wr_en = 1'b1;
            cnt_d = cnt_q - One;
            if (cnt_q == One) state_d = StDone;
          end
        end
        StDone: begin
          if (rd_start) begin
            rd_addr_d = wr_addr_q;
          end else if (rd_next) begin
            rd_addr_d = rd_addr_q + One;
          end
        end
        default: ;
      endcase
    end

    if (wr_en) wr_addr_d = wr_addr_q + One;
  end

  always_ff @(posedge src_clk or negedge reset_) begin
    if (!reset_) begin
      state_q     <= StIdle;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      trig_addr_q <= '0;
      pre_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      trig_addr_q <= trig_addr_d;
      pre_q       <= pre_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ram_wr_ena       = wr_en;
  assign ram_wr_addr      = wr_addr_q;
  assign rd_addr          = rd_addr_q;
  assign status_state     = state_q;
  assign status_trig_addr = trig_addr_q;

endmodule

// File: tb/tb_icetap_capture_ctrl.sv
// Bench for icetap_capture_ctrl: expected write addresses are queued per scenario and matched
// against every RAM write seen on the falling edge; status and read pointer checked directly.
module tb_icetap_capture_ctrl;

  localparam int unsigned AW = 4;
  localparam logic [1:0] Nop = 2'd0, Arm = 2'd1, Abort = 2'd2, Force = 2'd3;

  logic          src_clk = 1'b0;
  logic          reset_;
  logic          cmd_valid, store_match, trigger_match, rd_start, rd_next;
  logic [1:0]    cmd_code;
  logic [AW-1:0] cmd_pre_trig;
  logic          ram_wr_ena;
  logic [AW-1:0] ram_wr_addr, rd_addr, status_trig_addr;
  logic [2:0]    status_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [AW-1:0] exp_wr_q[$];

  icetap_capture_ctrl #(.ADDR_W(AW)) dut (
    .src_clk          (src_clk),
    .reset_           (reset_),
    .cmd_valid        (cmd_valid),
    .cmd_code         (cmd_code),
    .cmd_pre_trig     (cmd_pre_trig),
    .store_match      (store_match),
    .trigger_match    (trigger_match),
    .ram_wr_ena       (ram_wr_ena),
    .ram_wr_addr      (ram_wr_addr),
    .rd_start         (rd_start),
    .rd_next          (rd_next),
    .rd_addr          (rd_addr),
    .status_state     (status_state),
    .status_trig_addr (status_trig_addr)
  );

  always #5 src_clk = ~src_clk;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Every write the DUT makes must be the next one the scenario predicted.
  always @(negedge src_clk) begin
    if (reset_ === 1'b1 && ram_wr_ena === 1'b1) begin
      check_eq("wr_expected", int'(exp_wr_q.size() != 0), 1);
      if (exp_wr_q.size() != 0) check_eq("wr_addr", int'(ram_wr_addr), int'(exp_wr_q.pop_front()));
    end
  end

  // Drive one cycle of inputs, then return just after the committing edge.
  task automatic drive(input logic cv, input logic [1:0] code, input logic [AW-1:0] pre,
                       input logic st, input logic tr, input logic rs, input logic rn);
    cmd_valid = cv; cmd_code = code; cmd_pre_trig = pre;
    store_match = st; trigger_match = tr; rd_start = rs; rd_next = rn;
    @(posedge src_clk);
    #1;
    cmd_valid = 1'b0; cmd_code = Nop; store_match = 1'b0; trigger_match = 1'b0;
    rd_start = 1'b0; rd_next = 1'b0;
  endtask

  task automatic stores(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, Nop, '0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_range(input int first, input int n);
    for (int i = 0; i < n; i++) exp_wr_q.push_back(AW'((first + i) % 16));
  endtask

  initial begin
    reset_ = 1'b0;
    cmd_valid = 1'b0; cmd_code = Nop; cmd_pre_trig = '0;
    store_match = 1'b0; trigger_match = 1'b0; rd_start = 1'b0; rd_next = 1'b0;
    repeat (2) @(posedge src_clk);
    #1;
    check_eq("rst_state", int'(status_state), 0);
    check_eq("rst_wr_ena", int'(ram_wr_ena), 0);
    check_eq("rst_wr_addr", int'(ram_wr_addr), 0);
    check_eq("rst_rd_addr", int'(rd_addr), 0);
    check_eq("rst_trig", int'(status_trig_addr), 0);
    reset_ = 1'b1;
    @(posedge src_clk);
    #1;

    // IDLE ignores matches and FORCE_TRIG.
    drive(1'b1, Force, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    stores(2);
    check_eq("idle_force_state", int'(status_state), 0);
    check_eq("idle_wr_addr", int'(ram_wr_addr), 0);

    // Scenario 1: pre=4, continuous stores, trigger on the 10th cycle after ARM.
    push_range(0, 9);   // 4 PRE + 5 ARMED writes
    push_range(9, 1);   // trigger sample
    push_range(10, 11); // DEPTH-1-pre post samples
    drive(1'b1, Arm, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("s1_pre_state", int'(status_state), 1);
    check_eq("s1_arm_nowrite", int'(ram_wr_addr), 0);
    stores(4);
    check_eq("s1_armed_state", int'(status_state), 2);
    stores(5);
    drive(1'b0, Nop, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("s1_post_state", int'(status_state), 3);
    check_eq("s1_trig_addr", int'(status_trig_addr), 9);
    stores(10);
    check_eq("s1_still_post", int'(status_state), 3);
    stores(1);
    check_eq("s1_done_state", int'(status_state), 4);
    check_eq("s1_oldest", int'(ram_wr_addr), 5);
    check_eq("s1_pre_in_order", int'((status_trig_addr - ram_wr_addr) % 16), 4);
    drive(1'b1, Force, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("s1_done_force", int'(status_state), 4);
    check_eq("s1_done_hold", int'(ram_wr_addr), 5);
    check_eq("s1_drained", exp_wr_q.size(), 0);
    drive(1'b0, Nop, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("s1_rd_start", int'(rd_addr), 5);
    for (int i = 1; i <= 16; i++) begin
      drive(1'b0, Nop, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_eq("s1_rd_next", int'(rd_addr), (5 + i) % 16);
    end

    // Scenario 2: pre=0, trigger without store_match still writes.
    push_range(0, 16);
    drive(1'b1, Arm, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("s2_armed", int'(status_state), 2);
    drive(1'b0, Nop, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("s2_trig_addr", int'(status_trig_addr), 0);
    check_eq("s2_post", int'(status_state), 3);
    stores(15);
    check_eq("s2_done", int'(status_state), 4);
    check_eq("s2_wr_addr", int'(ram_wr_addr), 0);
    check_eq("s2_drained", exp_wr_q.size(), 0);

    // Scenario 3: pre=15, trigger_match ignored in PRE, FORCE_TRIG triggers in ARMED.
    push_range(0, 16);
    drive(1'b1, Arm, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) drive(1'b0, Nop, '0, 1'b1, (i < 3), 1'b0, 1'b0);
    check_eq("s3_armed", int'(status_state), 2);
    drive(1'b1, Force, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("s3_done", int'(status_state), 4);
    check_eq("s3_trig_addr", int'(status_trig_addr), 15);
    check_eq("s3_drained", exp_wr_q.size(), 0);
    drive(1'b0, Nop, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("s3_rd_start", int'(rd_addr), 0);
    for (int i = 0; i < 15; i++) drive(1'b0, Nop, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("s3_trig_last", int'(rd_addr), int'(status_trig_addr));

    // Scenario 5: ABORT during POST; read controls ignored outside DONE.
    push_range(0, 6);
    drive(1'b1, Arm, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    stores(2);
    drive(1'b0, Nop, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("s5_trig_addr", int'(status_trig_addr), 2);
    stores(2);
    drive(1'b0, Nop, '0, 1'b1, 1'b0, 1'b1, 1'b1);
    check_eq("s5_rd_hold", int'(rd_addr), 15);
    check_eq("s5_post", int'(status_state), 3);
    drive(1'b1, Abort, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("s5_idle", int'(status_state), 0);
    stores(3);
    check_eq("s5_wr_hold", int'(ram_wr_addr), 6);
    check_eq("s5_trig_hold", int'(status_trig_addr), 2);
    check_eq("s5_drained", exp_wr_q.size(), 0);

    // Scenario 6: asynchronous reset in the middle of POST.
    push_range(0, 3);
    drive(1'b1, Arm, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, Nop, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    stores(2);
    check_eq("s6_post", int'(status_state), 3);
    store_match = 1'b1;
    #2;
    reset_ = 1'b0;
    #1;
    check_eq("s6_async_state", int'(status_state), 0);
    check_eq("s6_async_wr_ena", int'(ram_wr_ena), 0);
    check_eq("s6_async_wr_addr", int'(ram_wr_addr), 0);
    check_eq("s6_async_trig", int'(status_trig_addr), 0);
    check_eq("s6_async_rd", int'(rd_addr), 0);
    check_eq("s6_drained", exp_wr_q.size(), 0);
    store_match = 1'b0;
    @(posedge src_clk);
    #1;
    reset_ = 1'b1;
    stores(2);
    check_eq("s6_idle_after", int'(status_state), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
